// File: rtl/vga_sync_decoder_if.sv
// rtl/vga_sync_decoder_if.sv - VGA sync input and decoded pixel/timing outputs
interface vga_sync_decoder_if;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_blank;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [18:0] mem_add;
  logic        pix_valid;
  logic        frame_start;
  logic [11:0] line_total;
  logic [10:0] frame_lines;
  logic        locked;
  logic        timing_err;

  modport master (
    output vga_hsync, vga_vsync, vga_blank,
    input  pix_x, pix_y, mem_add, pix_valid, frame_start,
    input  line_total, frame_lines, locked, timing_err
  );

  modport slave (
    input  vga_hsync, vga_vsync, vga_blank,
    output pix_x, pix_y, mem_add, pix_valid, frame_start,
    output line_total, frame_lines, locked, timing_err
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA sync decoder: pixel coordinates, line/frame measurement, lock FSM
module vga_sync_decoder #(
  parameter int HRES        = 640,
  parameter int VRES        = 480,
  parameter int HTOTAL      = 800,
  parameter int VTOTAL      = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  vga_sync_decoder_if.slave vga
);
  localparam int GW = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t      state_q, state_d;
  logic [GW-1:0] good_q, good_d, good_inc;
  logic        hs_r_q, hs_r_d, vs_r_q, vs_r_d, blank_r_q, blank_r_d;
  logic        hs_p_q, hs_p_d, vs_p_q, vs_p_d, blank_p_q, blank_p_d;
  logic [11:0] hcnt_q, hcnt_d, xcnt_q, xcnt_d, line_total_q, line_total_d;
  logic [10:0] lcnt_q, lcnt_d, ycnt_q, ycnt_d, frame_lines_q, frame_lines_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [18:0] mem_add_q, mem_add_d;
  logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
  logic        locked_q, locked_d, timing_err_q, timing_err_d;

  logic        hs_fall, vs_fall, blank_rise, blank_fall;
  logic        hsat, lsat, ysat, xsat, mismatch;
  logic [11:0] line_len, act_lines;
  logic [10:0] frame_len;
  logic [20:0] addr_full;

  always_comb begin
    hs_r_d    = vga.vga_hsync;
    vs_r_d    = vga.vga_vsync;
    blank_r_d = vga.vga_blank;
    hs_p_d    = hs_r_q;
    vs_p_d    = vs_r_q;
    blank_p_d = blank_r_q;

    hs_fall    = hs_p_q & ~hs_r_q;
    vs_fall    = vs_p_q & ~vs_r_q;
    blank_rise = ~blank_p_q & blank_r_q;
    blank_fall = blank_p_q & ~blank_r_q;

    hsat = (hcnt_q == 12'hFFF);
    lsat = (lcnt_q == 11'h7FF);
    ysat = (ycnt_q == 11'h7FF);
    xsat = (xcnt_q == 12'hFFF);

    line_len  = hsat ? 12'hFFF : hcnt_q + 12'd1;
    // A hsync fall coinciding with the vsync fall closes the frame being measured.
    frame_len = (lsat || !hs_fall) ? lcnt_q : lcnt_q + 11'd1;
    act_lines = {1'b0, ycnt_q} + {11'd0, blank_fall};

    hcnt_d       = hs_fall ? 12'd0 : (hsat ? hcnt_q : hcnt_q + 12'd1);
    line_total_d = hs_fall ? line_len : line_total_q;

    lcnt_d = lcnt_q;
    if (vs_fall)              lcnt_d = 11'd0;
    else if (hs_fall && !lsat) lcnt_d = lcnt_q + 11'd1;
    frame_lines_d = vs_fall ? frame_len : frame_lines_q;

    xcnt_d = xcnt_q;
    if (blank_rise)               xcnt_d = 12'd1;
    else if (blank_r_q && !xsat) xcnt_d = xcnt_q + 12'd1;

    ycnt_d = ycnt_q;
    if (vs_fall)                 ycnt_d = 11'd0;
    else if (blank_fall && !ysat) ycnt_d = ycnt_q + 11'd1;

    pix_x_d   = blank_r_q ? (blank_rise ? 10'd0 : xcnt_q[9:0]) : pix_x_q;
    pix_y_d   = blank_r_q ? ycnt_q[9:0] : pix_y_q;
    addr_full = 21'(pix_y_d) * 21'(HRES) + 21'(pix_x_d);
    mem_add_d = mem_add_q;
    if (blank_r_q) mem_add_d = (addr_full > 21'h7FFFF) ? 19'h7FFFF : addr_full[18:0];

    pix_valid_d   = blank_r_q & locked_q;
    frame_start_d = vs_fall;

    mismatch = (hs_fall && line_len != 12'(HTOTAL))
            || (blank_fall && xcnt_q != 12'(HRES))
            || (vs_fall && (frame_len != 11'(VTOTAL) || act_lines != 12'(VRES)))
            || hsat || lsat;

    state_d      = state_q;
    good_d       = good_q;
    good_inc     = good_q + 1'b1;
    timing_err_d = 1'b0;
    case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d = VERIFY;
          good_d  = '0;
        end
      end
      VERIFY: begin
        // A mismatch outranks a simultaneous vsync fall.
        if (mismatch) begin
          state_d      = SEARCH;
          timing_err_d = 1'b1;
        end else if (vs_fall) begin
          good_d = good_inc;
          if (good_inc == GW'(LOCK_FRAMES)) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (mismatch) begin
          state_d      = SEARCH;
          timing_err_d = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SEARCH;
      good_q        <= '0;
      hs_r_q        <= 1'b1;
      vs_r_q        <= 1'b1;
      blank_r_q     <= 1'b0;
      hs_p_q        <= 1'b1;
      vs_p_q        <= 1'b1;
      blank_p_q     <= 1'b0;
      hcnt_q        <= '0;
      xcnt_q        <= '0;
      line_total_q  <= '0;
      lcnt_q        <= '0;
      ycnt_q        <= '0;
      frame_lines_q <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      mem_add_q     <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      timing_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_q        <= good_d;
      hs_r_q        <= hs_r_d;
      vs_r_q        <= vs_r_d;
      blank_r_q     <= blank_r_d;
      hs_p_q        <= hs_p_d;
      vs_p_q        <= vs_p_d;
      blank_p_q     <= blank_p_d;
      hcnt_q        <= hcnt_d;
      xcnt_q        <= xcnt_d;
      line_total_q  <= line_total_d;
      lcnt_q        <= lcnt_d;
      ycnt_q        <= ycnt_d;
      frame_lines_q <= frame_lines_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      mem_add_q     <= mem_add_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      timing_err_q  <= timing_err_d;
    end
  end

  assign vga.pix_x       = pix_x_q;
  assign vga.pix_y       = pix_y_q;
  assign vga.mem_add     = mem_add_q;
  assign vga.pix_valid   = pix_valid_q;
  assign vga.frame_start = frame_start_q;
  assign vga.line_total  = line_total_q;
  assign vga.frame_lines = frame_lines_q;
  assign vga.locked      = locked_q;
  assign vga.timing_err  = timing_err_q;
endmodule
